inst_enc_loader: RTL
====================

// Module: inst_enc_loader
// PURPOSE
//  Instruction encoder/loader for the TCPU: the write-side counterpart of the instruction decoder.
//  Accepts field-level instruction requests over a valid/ready handshake and packs each into a
//  16-bit TCPU word. Writes the words sequentially into instruction memory, starting at address 0.
//  Used by the bench/boot path to place programs in imem; a run stops on HALT or memory full.
// PARAMETERS
//  AW   8   imem address width; depth = 2**AW words
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    reset, asynchronous, active-high
//  start        in   1    begin (or restart) a load at address 0
//  in_valid     in   1    request fields valid
//  in_ready     out  1    block can accept a request this cycle
//  kind         in   2    00 NOP, 01 ALU, 10 LI, 11 HALT
//  f_op         in   3    ALU op
//  f_wadr       in   2    destination register (ALU, LI)
//  f_aradr      in   2    source A register (ALU)
//  f_bradr      in   2    source B register (ALU)
//  f_hi         in   1    LI: 0 = load low byte (ll), 1 = load high byte (lh)
//  f_imm        in   8    LI immediate (ib)
//  imem_we      out  1    imem write strobe, one cycle per word
//  imem_addr    out  AW   imem write address
//  imem_wdata   out  16   encoded instruction word
//  busy         out  1    state is LOAD or WRITE
//  done         out  1    run finished, held until start or rst
//  overflow     out  1    run ended at full memory without HALT, held like done
//  count        out  AW+1 words written in the current or last run
// BEHAVIOUR
//  Encoding: all bits not listed below are 0.
//   NOP  = 16'h0000.
//   HALT = 16'h0001.
//   ALU  = [15:13]=000, [11:10]=f_wadr, [9:8]=f_bradr, [6:4]=f_op, [2]=1, [1:0]=f_aradr.
//   LI   = [15:13]=010, [11:10]=f_wadr, [8]=f_hi, [7:0]=f_imm.
//   Fields that do not apply to the selected kind are ignored.
//  Reset: state IDLE; every output 0 (imem_addr, imem_wdata and count included).
//  FSM:
//   IDLE : in_ready=0. start -> LOAD; addr=0, count=0.
//   LOAD : in_ready=1. in_valid&in_ready -> encode and register word and kind -> WRITE.
//   WRITE: in_ready=0, imem_we=1 for exactly this cycle; addr/wdata are stable registers.
//          Then, first match wins:
//          (1) kind==HALT           -> DONE.
//          (2) addr==2**AW-1        -> overflow=1 -> DONE.
//          (3) otherwise            -> addr+1 -> LOAD.
//          count increments on every WRITE cycle.
//   DONE : done=1. start -> LOAD; addr=0, count=0, done=0, overflow=0.
//  Timing and throughput:
//   - Latency from handshake to imem_we is 1 cycle; throughput is 1 word per 2 cycles.
//   - start is ignored in LOAD and WRITE; in_valid is ignored outside LOAD.
//  Boundaries and async reset:
//   - Address never wraps: full memory ends the run (case 2).
//   - HALT at the last address sets done=1 and overflow=0.
//   - rst mid-run aborts immediately: imem_we drops asynchronously and no partial word is retried.
//   - No combinational path from in_valid to in_ready.
// TESTING
//  1 ALU op=3 w=1 a=2 b=3, then HALT -> writes 16'h0736 @0, 16'h0001 @1; done=1, count=2, overflow=0.
//  2 LI lo w=2 imm=A5, LI hi w=3 imm=3C, NOP, HALT -> 16'h48A5, 16'h4D3C, 16'h0000, 16'h0001 @0..3.
//  3 in_valid held high continuously -> in_ready toggles; imem_we on alternate cycles, addrs 0,1,2 in order.
//  4 AW=2, four ALU requests and no HALT -> 4th write @3, overflow=1, done=1, count=4, in_ready=0.
//  5 rst asserted during WRITE -> imem_we=0 before the next edge; all outputs 0; state IDLE.
//  6 start in DONE -> done/overflow clear; next request is written at addr 0; start in LOAD has no effect.

Source files
------------

// File: rtl/inst_enc_loader_if.sv
// Request and imem-write bundle for the TCPU instruction encoder/loader.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready handshake; the imem side is write-only with no backpressure.
// Ports: master = request producer / imem consumer, slave = the loader.
//   in_valid, kind, f_op, f_wadr, f_aradr, f_bradr, f_hi, f_imm : request (master -> slave)
//   in_ready                                                     : accept (slave -> master)
//   imem_we, imem_addr, imem_wdata                               : imem write port (slave -> master)
interface inst_enc_loader_if #(
   parameter int AW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    kind;
   logic [2:0]    f_op;
   logic [1:0]    f_wadr;
   logic [1:0]    f_aradr;
   logic [1:0]    f_bradr;
   logic          f_hi;
   logic [7:0]    f_imm;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [15:0]   imem_wdata;

   modport master (
      output in_valid, kind, f_op, f_wadr, f_aradr, f_bradr, f_hi, f_imm,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, kind, f_op, f_wadr, f_aradr, f_bradr, f_hi, f_imm,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/inst_enc_loader.sv
// Packs field-level TCPU instruction requests into 16-bit words and writes them to imem from address 0.
// Latency: 1 cycle from accepted request to imem_we; throughput 1 word per 2 cycles.
// Backpressure: in_ready is high only in LOAD and depends on state alone, never on in_valid.
// Ports:
//   clk, rst        : clock, async active-high reset
//   start           : begin/restart a load at address 0 (honoured in IDLE and DONE only)
//   bus (slave)     : request fields + handshake, imem write strobe/address/data
//   busy            : LOAD or WRITE
//   done, overflow  : run finished / ended at full memory without HALT; held until start or rst
//   count           : words written in the current or last run
module inst_enc_loader #(
   parameter int AW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   inst_enc_loader_if.slave    bus,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [AW:0]         count
);

   localparam logic [1:0]    K_NOP  = 2'b00;
   localparam logic [1:0]    K_ALU  = 2'b01;
   localparam logic [1:0]    K_LI   = 2'b10;
   localparam logic [1:0]    K_HALT = 2'b11;
   localparam logic [AW-1:0] LAST   = {AW{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [1:0]    kind_q, kind_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;

   // Fields not used by the selected kind are dropped; every unlisted bit is 0.
   function automatic logic [15:0] encode(
      input logic [1:0] k,
      input logic [2:0] op,
      input logic [1:0] w,
      input logic [1:0] a,
      input logic [1:0] b,
      input logic       hi,
      input logic [7:0] imm
   );
      logic [15:0] word;
      word = 16'h0000;
      case (k)
         K_NOP:  word = 16'h0000;
         K_ALU:  word = {3'b000, 1'b0, w, b, 1'b0, op, 1'b0, 1'b1, a};
         K_LI:   word = {3'b010, 1'b0, w, 1'b0, hi, imm};
         K_HALT: word = 16'h0001;
         default: word = 16'h0000;
      endcase
      return word;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         kind_q  <= K_NOP;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         kind_q  <= kind_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      kind_d  = kind_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               addr_d  = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               wdata_d = encode(bus.kind, bus.f_op, bus.f_wadr, bus.f_aradr,
                                bus.f_bradr, bus.f_hi, bus.f_imm);
               kind_d  = bus.kind;
               state_d = WRITE;
            end
         end
         WRITE: begin
            count_d = count_q + 1'b1;
            // HALT takes priority, so HALT at the last address is a clean finish.
            if (kind_q == K_HALT) begin
               state_d = DONE;
            end else if (addr_q == LAST) begin
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from registers, so reset clears imem_we asynchronously.
   assign bus.in_ready   = (state_q == LOAD);
   assign bus.imem_we    = (state_q == WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign busy           = (state_q == LOAD) || (state_q == WRITE);
   assign done           = (state_q == DONE);
   assign overflow       = ovf_q;
   assign count          = count_q;

endmodule
